te_branch_map_multi: RTL

Parametrised branch-map accumulator for the instruction trace encoder. It records the taken/not-taken outcome of up to `NRET` retired conditional branches per cycle into a `MAP_LEN`-bit map. It reports count, full and empty status to the packet emitter and clears on emitter flush. Branches that overflow a filling map go into a small spill register and are replayed into the map after the flush. This generalises the single-retirement, fixed 31-bit map (`BRANCH_MAP_LEN`/`BRANCH_COUNT_LEN`) to multi-retire cores.

---
 rtl/te_branch_map_multi.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/te_branch_map_multi.sv
`default_nettype none
// ============================================================================
// Module      : te_branch_map_multi
// Description : Multi-lane branch-map accumulator for the trace encoder.
//               Compacts up to NRET retired branch outcomes per cycle into a
//               MAP_LEN-bit map, spills overflow and replays it after flush.
// Revision    : 1.0 - initial release
// ============================================================================
module te_branch_map_multi #(
    parameter int NRET      = 2,
    parameter int MAP_LEN   = 31,
    parameter int COUNT_LEN = $clog2(MAP_LEN + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NRET-1:0]      valid_i,
    input  logic [NRET-1:0]      taken_i,
    input  logic                 flush_i,
    output logic [MAP_LEN-1:0]   map_o,
    output logic [COUNT_LEN-1:0] count_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic                 lost_o,
    output logic                 error_o
);

    // Spill holds at most NRET-1 entries; keep at least one bit for NRET=1.
    localparam int C_SPILL_W = (NRET > 1) ? NRET - 1 : 1;
    localparam int C_SEQ_W   = 2 * NRET - 1;
    localparam int C_SCNT_W  = $clog2(NRET + 1);

    logic [MAP_LEN-1:0]   r_map;
    logic [COUNT_LEN-1:0] r_count;
    logic [C_SPILL_W-1:0] r_spill;
    logic [C_SCNT_W-1:0]  r_spill_cnt;
    logic                 r_lost;
    logic                 r_error;

    logic [NRET-1:0]      w_new;
    logic [C_SEQ_W-1:0]   w_seq;
    logic [MAP_LEN-1:0]   w_map_nxt;
    logic [C_SPILL_W-1:0] w_spill_nxt;
    int                   w_n;
    int                   w_sc;
    int                   w_base;
    int                   w_len;
    int                   w_pos;
    int                   w_total;
    int                   w_count_nxt;
    int                   w_spill_cnt_nxt;
    logic                 w_full;
    logic                 w_hold;
    logic                 w_drop;

    // Compact valid lanes, build the ordered bit sequence to insert and
    // place it into the map (or spill) starting at the insertion point.
    always_comb begin
        w_new           = '0;
        w_seq           = '0;
        w_map_nxt       = '0;
        w_spill_nxt     = '0;
        w_n             = 0;
        w_sc            = int'(r_spill_cnt);
        w_base          = 0;
        w_len           = 0;
        w_pos           = 0;
        w_total         = 0;
        w_count_nxt     = 0;
        w_spill_cnt_nxt = 0;
        w_full          = (int'(r_count) == MAP_LEN);

        // Lower lanes are older; invalid lanes leave no gap.
        for (int k = 0; k < NRET; k++) begin
            if (valid_i[k]) begin
                w_new[w_n] = ~taken_i[k];
                w_n        = w_n + 1;
            end
        end

        if (flush_i) begin
            // Post-flush map starts with replayed spill, then new bits.
            for (int j = 0; j < C_SPILL_W; j++) begin
                if (j < w_sc) begin
                    w_seq[j] = r_spill[j];
                end
            end
            for (int k = 0; k < NRET; k++) begin
                if (k < w_n) begin
                    w_seq[w_sc + k] = w_new[k];
                end
            end
            w_len     = w_sc + w_n;
            w_base    = 0;
            w_map_nxt = '0;
        end else begin
            for (int k = 0; k < NRET; k++) begin
                if (k < w_n) begin
                    w_seq[k] = w_new[k];
                end
            end
            w_len     = w_n;
            w_base    = int'(r_count);
            w_map_nxt = r_map;
        end

        for (int j = 0; j < C_SEQ_W; j++) begin
            if (j < w_len) begin
                w_pos = w_base + j;
                if (w_pos < MAP_LEN) begin
                    w_map_nxt[w_pos] = w_seq[j];
                end else if ((w_pos - MAP_LEN) < C_SPILL_W) begin
                    w_spill_nxt[w_pos - MAP_LEN] = w_seq[j];
                end
            end
        end

        w_total         = w_base + w_len;
        w_count_nxt     = (w_total > MAP_LEN) ? MAP_LEN : w_total;
        w_spill_cnt_nxt = (w_total > MAP_LEN) ? (w_total - MAP_LEN) : 0;

        // A full map without a flush freezes; any arriving branch is lost.
        w_hold = w_full && !flush_i;
        w_drop = w_hold && (w_n > 0);
    end

    // State register: map, count, spill and the loss indicators.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_map       <= '0;
            r_count     <= '0;
            r_spill     <= '0;
            r_spill_cnt <= '0;
            r_lost      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_lost <= w_drop;
            if (w_drop) begin
                r_error <= 1'b1;
            end else if (flush_i) begin
                r_error <= 1'b0;
            end
            if (!w_hold) begin
                r_map       <= w_map_nxt;
                r_count     <= COUNT_LEN'(w_count_nxt);
                r_spill     <= w_spill_nxt;
                r_spill_cnt <= C_SCNT_W'(w_spill_cnt_nxt);
            end
        end
    end

    assign map_o   = r_map;
    assign count_o = r_count;
    assign full_o  = w_full;
    assign empty_o = (r_count == '0);
    assign lost_o  = r_lost;
    assign error_o = r_error;

endmodule
`default_nettype wire
